// File: rtl/reg_file_pkg.sv
// Shared register-file sizing defaults and the streamer state encoding.
// Imported by reg_file and reg_file_streamer so both agree on B/W.
package reg_file_pkg;

  localparam int B_DEF = 8;
  localparam int W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FIN    = 2'd2
  } state_t;

endpackage

// File: rtl/reg_file.sv
// Register file: 2**W entries of B bits, synchronous write, asynchronous read.
// Read data follows r_addr combinationally; a write lands on the clock edge.
// No flow control; the reader owns sequencing.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int B = B_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  logic [B-1:0] mem [2**W];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/reg_file_streamer.sv
// Walks `count` register-file addresses from base_addr and streams the words out.
// Latency: start sampled at edge N gives out_valid after edge N+1, then one word per cycle.
// Backpressure: a stalled word holds data/last/pointer until out_ready accepts it.
module reg_file_streamer
  import reg_file_pkg::*;
#(
  parameter int B = B_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] base_addr,
  input  logic [W:0]   count,
  output logic [W-1:0] rd_addr,
  input  logic [B-1:0] rd_data,
  output logic [B-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam logic [W:0] REM_MAX = (W+1)'(2**W);

  state_t       state;
  logic [W-1:0] ptr;
  logic [W:0]   rem;
  logic [W:0]   count_sat;
  logic         load;
  logic         hs;

  assign count_sat = (count > REM_MAX) ? REM_MAX : count;
  assign hs        = out_valid & out_ready;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign load      = (rem != '0) && (!out_valid || out_ready);
  assign rd_addr   = ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      rem       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr <= base_addr;
            rem <= count_sat;
            if (count_sat == '0) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state <= ST_STREAM;
              busy  <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (load) begin
            out_data  <= rd_data;
            out_valid <= 1'b1;
            out_last  <= (rem == (W+1)'(1));
            ptr       <= ptr + 1'b1;
            rem       <= rem - 1'b1;
          end else if (hs) begin
            out_valid <= 1'b0;
          end
          // rem is already zero once the last word is out, so no load competes here.
          if (hs && out_last) begin
            state    <= ST_FIN;
            out_last <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_streamer.sv
// Bench: reg_file feeding reg_file_streamer, checked against a queue-based burst model.
module tb_reg_file_streamer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] base_addr;
  logic [2:0] count;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file #(.B(8), .W(2)) u_rf (
    .clk    (clk),
    .we     (we),
    .w_addr (waddr),
    .w_data (wdata),
    .r_addr (rd_addr),
    .r_data (rd_data)
  );

  reg_file_streamer #(.B(8), .W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image plus the list of addresses still owed to the consumer.
  logic [7:0] mem_m [4];
  int         pend[$];
  bit         active = 0;
  bit         fresh = 0;
  bit         done_due = 0;
  bit         stall_prev = 0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [7:0] got[$];
  logic       got_last[$];
  int         cyc = 0;
  int         acc_cyc = -1, first_hs_cyc = -1, last_hs_cyc = -1, done_cyc = -1;

  always @(negedge clk) begin
    bit exp_valid;
    bit dn;
    bit idle_now;
    int n;
    cyc++;
    exp_valid = active && !fresh && (pend.size() > 0);
    chk("out_valid", out_valid, exp_valid);
    chk("busy", busy, active);
    chk("done", done, done_due);
    if (done) done_cyc = cyc;
    if (exp_valid) begin
      chk("out_data", out_data, mem_m[pend[0]]);
      chk("out_last", out_last, pend.size() == 1);
      chk("rd_addr_next", rd_addr, (pend[0] + 1) % 4);
    end else if (fresh) begin
      chk("rd_addr_first", rd_addr, pend[0]);
    end
    if (stall_prev) begin
      chk("stall_data", out_data, prev_data);
      chk("stall_last", out_last, prev_last);
    end

    stall_prev = exp_valid && !out_ready && !reset;
    prev_data  = out_data;
    prev_last  = out_last;
    idle_now   = !active && !done_due;
    dn         = 0;
    if (exp_valid && out_ready) begin
      if (got.size() == 0) first_hs_cyc = cyc;
      got.push_back(out_data);
      got_last.push_back(out_last);
      void'(pend.pop_front());
      if (pend.size() == 0) begin
        active      = 0;
        dn          = 1;
        last_hs_cyc = cyc;
      end
    end
    if (reset) begin
      pend.delete();
      active   = 0;
      fresh    = 0;
      done_due = 0;
    end else begin
      fresh = 0;
      if (start && idle_now) begin
        n       = (count > 4) ? 4 : int'(count);
        acc_cyc = cyc;
        if (n == 0) dn = 1;
        else begin
          active = 1;
          fresh  = 1;
          for (int k = 0; k < n; k++) pend.push_back((int'(base_addr) + k) % 4);
        end
      end
      done_due = dn;
    end
    if (we) mem_m[waddr] = wdata;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input int d);
    we = 1; waddr = 2'(a); wdata = 8'(d);
    tick();
    we = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1 pattern; 3: stray start mid-burst; 4: write [3]=55 mid-burst
  task automatic run_burst(input int b, input int c, input int mode);
    bit seen;
    got.delete(); got_last.delete();
    out_ready = 1;
    base_addr = 2'(b); count = 3'(c); start = 1;
    tick();
    start = 0;
    seen = done;
    for (int i = 0; i < 64 && !seen; i++) begin
      out_ready = (mode == 1) ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      if (mode == 3 && i == 1) begin
        start = 1; base_addr = 2'd2; count = 3'd1;
      end else start = 0;
      if (mode == 4 && i == 0) begin
        we = 1; waddr = 2'd3; wdata = 8'h55;
      end else we = 0;
      tick();
      if (done) seen = 1;
    end
    start = 0; we = 0; out_ready = 1;
    chk("burst_done_seen", seen, 1);
    tick();
  endtask

  initial begin
    reset = 1; start = 0; base_addr = 0; count = 0; out_ready = 1;
    we = 0; waddr = 0; wdata = 0;
    tick(); tick();
    check_reset_outputs("reset");
    reset = 0;
    wr(0, 8'hA1); wr(1, 8'hB2); wr(2, 8'hC3); wr(3, 8'hD4);
    tick();

    // Basic burst
    run_burst(0, 4, 0);
    chk("basic_n", got.size(), 4);
    chk("basic_w0", got[0], 8'hA1);
    chk("basic_w1", got[1], 8'hB2);
    chk("basic_w2", got[2], 8'hC3);
    chk("basic_w3", got[3], 8'hD4);
    chk("basic_last3", got_last[3], 1);
    chk("basic_last2", got_last[2], 0);
    chk("basic_latency", first_hs_cyc - acc_cyc, 2);
    chk("basic_no_bubble", last_hs_cyc - first_hs_cyc, 3);
    chk("basic_done_lag", done_cyc - last_hs_cyc, 1);

    // Wrap and saturation
    run_burst(3, 3, 0);
    chk("wrap_n", got.size(), 3);
    chk("wrap_w0", got[0], 8'hD4);
    chk("wrap_w1", got[1], 8'hA1);
    chk("wrap_w2", got[2], 8'hB2);
    chk("wrap_last", got_last[2], 1);
    run_burst(1, 7, 0);
    chk("sat_n", got.size(), 4);
    chk("sat_w3", got[3], 8'hA1);

    // Backpressure
    run_burst(0, 4, 1);
    chk("bp_n", got.size(), 4);
    chk("bp_w0", got[0], 8'hA1);
    chk("bp_w3", got[3], 8'hD4);

    // Zero count and ignored start
    run_burst(2, 0, 0);
    chk("zero_n", got.size(), 0);
    chk("zero_done_lag", done_cyc - acc_cyc, 1);
    run_burst(0, 4, 3);
    chk("ign_n", got.size(), 4);
    chk("ign_w0", got[0], 8'hA1);
    chk("ign_w3", got[3], 8'hD4);

    // Reset mid-burst
    got.delete(); got_last.delete();
    out_ready = 1; base_addr = 0; count = 4; start = 1;
    tick();
    start = 0;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    check_reset_outputs("rst_mid");
    chk("rst_mid_words", got.size(), 2);
    repeat (4) tick();
    run_burst(0, 4, 0);
    chk("post_rst_n", got.size(), 4);
    chk("post_rst_w1", got[1], 8'hB2);

    // Concurrent write ahead of the read pointer
    run_burst(0, 4, 4);
    chk("cw_n", got.size(), 4);
    chk("cw_w0", got[0], 8'hA1);
    chk("cw_w3", got[3], 8'h55);
    wr(3, 8'hD4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      base_addr = 2'($urandom);
      count     = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      we        = !active && ($urandom_range(0, 3) == 0);
      waddr     = 2'($urandom);
      wdata     = 8'($urandom);
      tick();
    end
    start = 0; reset = 0; we = 0; out_ready = 1;
    repeat (20) tick();
    chk("drain_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
